// File: rtl/gemm_tile_loader.sv
// gemm_tile_loader: accepts DEPTH source rows of NUM lanes over a valid/ready
// handshake and replays each one, one cycle later, as a one-hot write enable
// plus registered row data for an external per-row flip-flop array. Once the
// last row has been written the tile is held (tile_valid) until tile_ack.
//
// Optional feature: define GEMM_TILE_LOADER_PERF_EN to add the 16-bit
// stall_cycles output (LOAD cycles spent waiting for in_valid, saturating).
module gemm_tile_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM        = 4,
  parameter int DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM-1:0][DATA_WIDTH-1:0]   in_data,
  output logic [DEPTH-1:0]                 row_enable,
  output logic [NUM-1:0][DATA_WIDTH-1:0]   row_data,
  output logic                             tile_valid,
  input  logic                             tile_ack,
  output logic                             busy,
  output logic [$clog2(DEPTH+1)-1:0]       loaded_rows
`ifdef GEMM_TILE_LOADER_PERF_EN
  ,
  output logic [15:0]                      stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH-1);
  localparam logic [DEPTH-1:0] ONE_HOT0 = DEPTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] ptr;
  logic          accept;
  logic          start_take;

  // Abort wins over a same-cycle handshake, so it masks acceptance outright.
  assign accept     = in_valid & in_ready & ~abort;
  // A start is honoured from IDLE, or from HOLD together with tile_ack.
  assign start_take = start & ((state == IDLE) | ((state == HOLD) & tile_ack));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred for state_nx.
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD: begin
        if (abort)                          state_nx = IDLE;
        else if (accept && ptr == LAST_PTR) state_nx = DRAIN;
      end
      DRAIN:   state_nx = HOLD;
      HOLD:    if (tile_ack) state_nx = start ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready   = (state == LOAD);
    tile_valid = (state == HOLD);
    busy       = (state != IDLE);
  end

  // Row pointer, accepted-row count and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      loaded_rows <= '0;
      row_enable  <= '0;
      row_data    <= '0;
    end else begin
      row_enable <= '0;
      if (start_take) begin
        ptr         <= '0;
        loaded_rows <= '0;
      end else if (accept) begin
        row_enable  <= ONE_HOT0 << ptr;
        row_data    <= in_data;
        ptr         <= (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
        loaded_rows <= loaded_rows + LW'(1);
      end else if (state == LOAD && abort) begin
        ptr <= '0;
      end
    end
  end

`ifdef GEMM_TILE_LOADER_PERF_EN
  // Count LOAD cycles starved of input; cleared by each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (start_take) begin
      stall_cycles <= '0;
    end else if (state == LOAD && !in_valid && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_tile_loader.sv
// Directed bench for gemm_tile_loader (DEPTH=4, NUM=4, DATA_WIDTH=32).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_gemm_tile_loader;

  typedef logic [3:0][31:0] row_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  row_t       in_data;
  logic [3:0] row_enable;
  row_t       row_data;
  logic       tile_valid;
  logic       tile_ack;
  logic       busy;
  logic [2:0] loaded_rows;
`ifdef GEMM_TILE_LOADER_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  gemm_tile_loader #(.DATA_WIDTH(32), .NUM(4), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .row_enable  (row_enable),
    .row_data    (row_data),
    .tile_valid  (tile_valid),
    .tile_ack    (tile_ack),
    .busy        (busy),
    .loaded_rows (loaded_rows)
`ifdef GEMM_TILE_LOADER_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Row r carries byte 0x11*(r+1) in every lane, tagged with the lane index.
  function automatic row_t mk_row(input int r);
    row_t v;
    for (int i = 0; i < 4; i++) v[i] = 32'((r + 1) * 32'h11) | 32'(i << 16);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; in_valid = 0; tile_ack = 0; in_data = '0;
  endtask

  // Stimulus only: start a tile and stream four back-to-back rows into DRAIN.
  task automatic load_tile();
    start = 1; step(); start = 0;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1; in_data = mk_row(r); step();
    end
    in_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    checks++; if (row_enable !== 4'b0)  begin errors++; $display("FAIL reset_row_enable got %b exp 0000", row_enable); end
    checks++; if (row_data !== '0)       begin errors++; $display("FAIL reset_row_data got %h exp 0", row_data); end
    checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (tile_valid !== 1'b0)   begin errors++; $display("FAIL reset_tile_valid got %b exp 0", tile_valid); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (loaded_rows !== 3'd0)  begin errors++; $display("FAIL reset_loaded_rows got %0d exp 0", loaded_rows); end
    rst = 0;
    step();
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  // Back-to-back tile, with start held through DRAIN and HOLD (ignored).
  task automatic test_back_to_back();
    start = 1; step(); start = 0;
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    checks++; if (loaded_rows !== 3'd0) begin errors++; $display("FAIL b2b_loaded0 got %0d exp 0", loaded_rows); end
    checks++; if (row_enable !== 4'b0)  begin errors++; $display("FAIL b2b_en_idle got %b exp 0000", row_enable); end
    for (int r = 0; r < 4; r++) begin
      in_valid = 1; in_data = mk_row(r); step();
      checks++; if (row_enable !== 4'(1 << r)) begin errors++; $display("FAIL b2b_en_row%0d got %b exp %b", r, row_enable, 4'(1 << r)); end
      checks++; if (row_data !== mk_row(r))    begin errors++; $display("FAIL b2b_data_row%0d got %h exp %h", r, row_data, mk_row(r)); end
      checks++; if (loaded_rows !== 3'(r + 1)) begin errors++; $display("FAIL b2b_loaded_row%0d got %0d exp %0d", r, loaded_rows, r + 1); end
    end
    in_valid = 0; in_data = '0;
    // DRAIN: last enable visible, not yet valid.
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL drain_in_ready got %b exp 0", in_ready); end
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL drain_tile_valid got %b exp 0", tile_valid); end
    start = 1; step();
    checks++; if (tile_valid !== 1'b1)  begin errors++; $display("FAIL hold_tile_valid got %b exp 1", tile_valid); end
    checks++; if (row_enable !== 4'b0)  begin errors++; $display("FAIL hold_row_enable got %b exp 0000", row_enable); end
    checks++; if (row_data !== mk_row(3)) begin errors++; $display("FAIL hold_row_data got %h exp %h", row_data, mk_row(3)); end
    checks++; if (loaded_rows !== 3'd4) begin errors++; $display("FAIL hold_loaded got %0d exp 4", loaded_rows); end
    step(); step();
    checks++; if (tile_valid !== 1'b1)  begin errors++; $display("FAIL hold_start_ignored got %b exp 1", tile_valid); end
    checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL hold_in_ready got %b exp 0", in_ready); end
    checks++; if (loaded_rows !== 3'd4) begin errors++; $display("FAIL hold_loaded_kept got %0d exp 4", loaded_rows); end
    start = 0; tile_ack = 1; step(); tile_ack = 0;
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL ack_tile_valid got %b exp 0", tile_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL ack_busy got %b exp 0", busy); end
  endtask

  // Three idle cycles between rows: no enables during gaps, 9 stall cycles.
  task automatic test_gaps();
    start = 1; step(); start = 0;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1; in_data = mk_row(r); step();
      checks++; if (row_enable !== 4'(1 << r)) begin errors++; $display("FAIL gap_en_row%0d got %b exp %b", r, row_enable, 4'(1 << r)); end
      in_valid = 0;
      if (r < 3) begin
        for (int g = 0; g < 3; g++) begin
          step();
          checks++; if (row_enable !== 4'b0) begin errors++; $display("FAIL gap_en_quiet%0d_%0d got %b exp 0000", r, g, row_enable); end
          checks++; if (row_data !== mk_row(r)) begin errors++; $display("FAIL gap_data_hold%0d_%0d got %h exp %h", r, g, row_data, mk_row(r)); end
        end
      end
    end
    step();
    checks++; if (tile_valid !== 1'b1) begin errors++; $display("FAIL gap_tile_valid got %b exp 1", tile_valid); end
`ifdef GEMM_TILE_LOADER_PERF_EN
    checks++; if (stall_cycles !== 16'd9) begin errors++; $display("FAIL gap_stall_cycles got %0d exp 9", stall_cycles); end
`endif
    tile_ack = 1; step(); tile_ack = 0;
  endtask

  // Abort together with the third handshake: only two enables.
  task automatic test_abort();
    // abort is ignored in IDLE: start still goes to LOAD.
    abort = 1; start = 1; step(); abort = 0; start = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_idle_ignored got %b exp 1", busy); end
    for (int r = 0; r < 2; r++) begin
      in_valid = 1; in_data = mk_row(r); step();
      checks++; if (row_enable !== 4'(1 << r)) begin errors++; $display("FAIL abort_en_row%0d got %b exp %b", r, row_enable, 4'(1 << r)); end
    end
    in_data = mk_row(2); abort = 1; step(); abort = 0; in_valid = 0;
    checks++; if (row_enable !== 4'b0)    begin errors++; $display("FAIL abort_no_enable got %b exp 0000", row_enable); end
    checks++; if (row_data !== mk_row(1)) begin errors++; $display("FAIL abort_row_data got %h exp %h", row_data, mk_row(1)); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL abort_in_ready got %b exp 0", in_ready); end
    step();
    checks++; if (row_enable !== 4'b0)    begin errors++; $display("FAIL abort_after_en got %b exp 0000", row_enable); end
    // After abort a new tile starts from row 0.
    start = 1; step(); start = 0;
    in_valid = 1; in_data = mk_row(0); step(); in_valid = 0;
    checks++; if (row_enable !== 4'b0001) begin errors++; $display("FAIL abort_restart_ptr got %b exp 0001", row_enable); end
    abort = 1; step(); abort = 0;
  endtask

  // HOLD with tile_ack and start together: straight into LOAD.
  task automatic test_ack_start();
    load_tile();
    step();
    checks++; if (tile_valid !== 1'b1) begin errors++; $display("FAIL ackst_hold got %b exp 1", tile_valid); end
    tile_ack = 1; start = 1; step(); tile_ack = 0; start = 0;
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL ackst_in_ready got %b exp 1", in_ready); end
    checks++; if (tile_valid !== 1'b0)  begin errors++; $display("FAIL ackst_tile_valid got %b exp 0", tile_valid); end
    checks++; if (loaded_rows !== 3'd0) begin errors++; $display("FAIL ackst_loaded got %0d exp 0", loaded_rows); end
    in_valid = 1; in_data = mk_row(2); step(); in_valid = 0;
    checks++; if (row_enable !== 4'b0001) begin errors++; $display("FAIL ackst_ptr got %b exp 0001", row_enable); end
    abort = 1; step(); abort = 0;
  endtask

  // Asynchronous reset mid-load, then a clean tile.
  task automatic test_reset_midload();
    start = 1; step(); start = 0;
    in_valid = 1; in_data = mk_row(0); step();
    in_data = mk_row(1); step();
    #2 rst = 1;
    #1;
    checks++; if (row_enable !== 4'b0)  begin errors++; $display("FAIL arst_row_enable got %b exp 0000", row_enable); end
    checks++; if (row_data !== '0)       begin errors++; $display("FAIL arst_row_data got %h exp 0", row_data); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL arst_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL arst_in_ready got %b exp 0", in_ready); end
    checks++; if (loaded_rows !== 3'd0)  begin errors++; $display("FAIL arst_loaded got %0d exp 0", loaded_rows); end
    in_valid = 0; in_data = '0;
    step();
    checks++; if (row_enable !== 4'b0)  begin errors++; $display("FAIL arst_no_pulse got %b exp 0000", row_enable); end
    rst = 0;
    start = 1; step(); start = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_first_start got %b exp 1", in_ready); end
    for (int r = 0; r < 4; r++) begin
      in_valid = 1; in_data = mk_row(r); step();
      checks++; if (row_enable !== 4'(1 << r)) begin errors++; $display("FAIL arst_en_row%0d got %b exp %b", r, row_enable, 4'(1 << r)); end
      checks++; if (row_data !== mk_row(r))    begin errors++; $display("FAIL arst_data_row%0d got %h exp %h", r, row_data, mk_row(r)); end
    end
    in_valid = 0;
    step();
    checks++; if (tile_valid !== 1'b1)  begin errors++; $display("FAIL arst_tile_valid got %b exp 1", tile_valid); end
    checks++; if (loaded_rows !== 3'd4) begin errors++; $display("FAIL arst_loaded4 got %0d exp 4", loaded_rows); end
    tile_ack = 1; step(); tile_ack = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_ack_start();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gemm_tile_loader.md
GEMM_TILE_LOADER -- requirements
Module: gemm_tile_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, bits per lane element.
REQ-002 The block SHALL have parameter NUM, default 4, lanes per row.
REQ-003 The block SHALL have parameter DEPTH, default 4, rows per tile (DEPTH >= 2).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high, on ports clk and rst.
REQ-005 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit, request to begin loading a tile.
REQ-008 The block SHALL have port abort, input, 1 bit, cancel an in-progress load.
REQ-009 The block SHALL have port in_valid, input, 1 bit, source row valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit, loader accepts a row.
REQ-011 The block SHALL have port in_data, input, [NUM-1:0][DATA_WIDTH-1:0], source row.
REQ-012 The block SHALL have port row_enable, output, DEPTH bits, one-hot write enable for the external per-row flip-flop arrays.
REQ-013 The block SHALL have port row_data, output, [NUM-1:0][DATA_WIDTH-1:0], registered row presented with row_enable.
REQ-014 The block SHALL have port tile_valid, output, 1 bit, a complete tile is held.
REQ-015 The block SHALL have port tile_ack, input, 1 bit, consumer releases the tile.
REQ-016 The block SHALL have port busy, output, 1 bit, state is not IDLE.
REQ-017 The block SHALL have port loaded_rows, output, $clog2(DEPTH+1) bits, rows accepted in the current tile.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, DRAIN and HOLD.
REQ-019 In IDLE, start=1 SHALL move the FSM to LOAD and clear the row pointer and loaded_rows.
REQ-020 In LOAD, in_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-021 A handshake SHALL be in_valid & in_ready at a rising edge.
REQ-022 On a handshake, the next cycle SHALL assert row_enable[ptr] alone, with row_data = the accepted in_data (1-cycle latency).
REQ-023 A handshake SHALL increment ptr and loaded_rows.
REQ-024 In any cycle following no handshake, row_enable SHALL be 0.
REQ-025 row_data SHALL hold its last value when row_enable is 0.
REQ-026 A handshake at ptr = DEPTH-1 SHALL move the FSM to DRAIN, and ptr SHALL wrap to 0.
REQ-027 DRAIN SHALL last exactly one cycle (the last row_enable), then move to HOLD.
REQ-028 In HOLD, tile_valid SHALL be 1; tile_valid SHALL be 0 in all other states.
REQ-029 In HOLD, tile_ack=1 SHALL move the FSM to IDLE; tile_ack and start both 1 SHALL move it directly to LOAD with ptr and loaded_rows cleared.
REQ-030 start SHALL be ignored in LOAD and DRAIN; tile_ack SHALL be ignored outside HOLD.
REQ-031 abort=1 in LOAD SHALL take priority over a same-cycle handshake: no row SHALL be accepted, no further row_enable SHALL be asserted, and the FSM SHALL go to IDLE with ptr=0.
REQ-032 abort SHALL be ignored in IDLE, DRAIN and HOLD.
REQ-033 In LOAD, in_valid=0 SHALL stall the FSM indefinitely with no timeout.

Reset
REQ-034 rst=1 SHALL asynchronously force: state IDLE, ptr 0, loaded_rows 0, row_enable 0, row_data 0, in_ready 0, tile_valid 0, busy 0.
REQ-035 rst asserted mid-load or in HOLD SHALL discard the tile, and no row_enable SHALL pulse after reset.
REQ-036 The first start is honoured on the first rising edge after rst deasserts.

Configuration
REQ-037 Macro GEMM_TILE_LOADER_PERF_EN defined SHALL add output stall_cycles, 16 bits, which counts LOAD cycles with in_valid=0, saturates at 16'hFFFF, clears when a start is accepted, and resets to 0.
REQ-038 With GEMM_TILE_LOADER_PERF_EN undefined, the stall_cycles port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 DEPTH=4: start, then 4 back-to-back valid rows 0x11..0x44 -> row_enable 0001,0010,0100,1000 on cycles 2..5 with matching row_data, tile_valid from cycle 6, loaded_rows=4.
REQ-040 in_valid gaps of 3 cycles between rows -> no row_enable during the gaps, and stall_cycles=9 with PERF_EN defined.
REQ-041 abort in the same cycle as the 3rd row handshake -> only 2 row_enable pulses, busy=0 next cycle, in_ready=0.
REQ-042 HOLD with tile_ack=1 and start=1 together -> FSM goes directly to LOAD, in_ready=1 next cycle, tile_valid=0, loaded_rows=0.
REQ-043 rst pulse during LOAD after 2 rows -> all outputs 0 immediately (asynchronously), then a fresh start loads 4 rows correctly from row 0.
REQ-044 start asserted during DRAIN and HOLD without tile_ack -> ignored, tile_valid stays 1 until tile_ack.
